// File: rtl/fnc_vgatiming_gen_pkg.sv
// Shared definitions for the VGA timing generator: 640x480@60 geometry
// defaults, total-period and counter-width helpers, and the bundle of
// per-pixel control flags that travels down the sync/blank delay pipe.
package fnc_vgatiming_gen_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 4;
  localparam int DEF_ADDR_W   = 19;

  // Flags are active-high "in region" indicators so that an all-zero
  // (reset or flushed) pipe stage means blank, syncs inactive, no pulse.
  typedef struct packed {
    logic hs_on;
    logic vs_on;
    logic h_act;
    logic v_act;
    logic fs;
  } vga_ctl_t;

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fnc_vgatiming_gen_if.sv
// Display-side bundle of the VGA timing generator.
//   module_en, scale2x, fb_base : control inputs (sampled at frame start)
//   addr / data                 : VRAM read address out, pixel {R,G,B} in
//   hsync, vsync                : sync outputs
//   hblank, vblank, frame_start : blanking flags and frame pulse (rgb-aligned)
//   rdata, gdata, bdata         : pixel colour out
// master = timing generator side, slave = system / display side.
interface fnc_vgatiming_gen_if #(
  parameter int CW     = 4,
  parameter int ADDR_W = 19
) ();
  logic              module_en;
  logic              scale2x;
  logic [ADDR_W-1:0] fb_base;
  logic [ADDR_W-1:0] addr;
  logic [3*CW-1:0]   data;
  logic              hsync;
  logic              vsync;
  logic              hblank;
  logic              vblank;
  logic              frame_start;
  logic [CW-1:0]     rdata;
  logic [CW-1:0]     gdata;
  logic [CW-1:0]     bdata;

  modport master (
    input  module_en, scale2x, fb_base, data,
    output addr, hsync, vsync, hblank, vblank, frame_start, rdata, gdata, bdata
  );

  modport slave (
    output module_en, scale2x, fb_base, data,
    input  addr, hsync, vsync, hblank, vblank, frame_start, rdata, gdata, bdata
  );
endinterface

// File: rtl/fnc_vga_delayline.sv
// Fixed-depth shift register with asynchronous active-high clear.
//   clk, rst : clock, async reset (all stages cleared to zero)
//   din      : WIDTH-bit input, dout : din delayed by DEPTH clocks (DEPTH>=1)
module fnc_vga_delayline #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/fnc_vgatiming_gen.sv
// Programmable VGA timing and pixel-fetch engine on the pixel clock.
//   clk : pixel clock        rst : asynchronous reset, active-high
//   vga : fnc_vgatiming_gen_if.master (controls, VRAM port, display pins)
// Counter state at cycle n -> addr at n+1 -> VRAM data at n+1+RD_LATENCY ->
// registered outputs at n+2+RD_LATENCY; sync/blank/frame_start follow the
// same total delay so every output stays aligned with rgb.
module fnc_vgatiming_gen
  import fnc_vgatiming_gen_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CW         = DEF_CW,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  fnc_vgatiming_gen_if.master vga
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  // One spare count of headroom so sync-end constants always fit.
  localparam int HW   = cnt_w(H_TOTAL + 1);
  localparam int VW   = cnt_w(V_TOTAL + 1);
  localparam int PIPE = RD_LATENCY + 2;

  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              scale_q, scale_d;

  logic              origin, scale_eff, h_act, v_act, line_end, frame_end;
  logic [ADDR_W-1:0] base_eff, x_off, line_w;
  vga_ctl_t          ctl_in, ctl_dly;

  logic [CW-1:0]     r_q, g_q, b_q;
  logic              hsync_q, vsync_q, hblank_q, vblank_q, fs_q;

  always_comb begin
    origin    = (hcnt_q == '0) && (vcnt_q == '0);
    // At the frame origin the shadows are being loaded this very cycle, so
    // the first pixel's address uses the live inputs directly.
    scale_eff = origin ? vga.scale2x : scale_q;
    base_eff  = origin ? vga.fb_base : row_base_q;
    x_off     = scale_eff ? ADDR_W'(hcnt_q >> 1) : ADDR_W'(hcnt_q);
    line_w    = scale_q ? ADDR_W'(H_ACTIVE / 2) : ADDR_W'(H_ACTIVE);
    h_act     = hcnt_q < H_ACT_C;
    v_act     = vcnt_q < V_ACT_C;
    line_end  = hcnt_q == H_LAST;
    frame_end = line_end && (vcnt_q == V_LAST);

    hcnt_d     = hcnt_q + 1'b1;
    vcnt_d     = vcnt_q;
    row_base_d = origin ? vga.fb_base : row_base_q;
    scale_d    = origin ? vga.scale2x : scale_q;
    addr_d     = (vga.module_en && h_act && v_act) ? base_eff + x_off : addr_q;

    if (line_end) begin
      hcnt_d = '0;
      if (frame_end) begin
        vcnt_d     = '0;
        row_base_d = vga.fb_base;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
        // In 2x mode each VRAM row is shown on two lines: advance after odd lines.
        if (v_act && (!scale_q || vcnt_q[0])) row_base_d = row_base_q + line_w;
      end
    end

    if (!vga.module_en) begin
      hcnt_d     = '0;
      vcnt_d     = '0;
      row_base_d = vga.fb_base;
      scale_d    = vga.scale2x;
    end

    ctl_in.hs_on = vga.module_en && (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    ctl_in.vs_on = vga.module_en && (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    ctl_in.h_act = vga.module_en && h_act;
    ctl_in.v_act = vga.module_en && v_act;
    ctl_in.fs    = vga.module_en && origin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      scale_q    <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      scale_q    <= scale_d;
    end
  end

  // The final output register supplies the last stage of the PIPE delay.
  fnc_vga_delayline #(
    .WIDTH($bits(vga_ctl_t)),
    .DEPTH(PIPE - 1)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (ctl_in),
    .dout (ctl_dly)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      hsync_q  <= ctl_dly.hs_on ? HS_POL : ~HS_POL;
      vsync_q  <= ctl_dly.vs_on ? VS_POL : ~VS_POL;
      hblank_q <= ~ctl_dly.h_act;
      vblank_q <= ~ctl_dly.v_act;
      fs_q     <= ctl_dly.fs;
      if (ctl_dly.h_act && ctl_dly.v_act) {r_q, g_q, b_q} <= vga.data;
      else                                {r_q, g_q, b_q} <= '0;
    end
  end

  assign vga.addr        = addr_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.hblank      = hblank_q;
  assign vga.vblank      = vblank_q;
  assign vga.frame_start = fs_q;
  assign vga.rdata       = r_q;
  assign vga.gdata       = g_q;
  assign vga.bdata       = b_q;

endmodule
